// File: rtl/seq_alu.sv
// seq_alu: N-bit MIPS ALU with start/busy/done handshake,
// iterative MULU/DIVU, HI/LO registers.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   a, b          operands, sampled only on an accepted start
//   selector      4-bit opcode, sampled only on an accepted start
//   start         request, accepted only while busy=0
//   result        registered result, held until the next completion
//   zero          registered, result==0
//   overflow      registered, signed overflow of ADD/SUB
//   div_by_zero   registered, last completed op was DIVU with b==0
//   busy          high while MULU/DIVU(/MULS) is iterating
//   done          one-cycle pulse when result/flags update
//   hi, lo        HI/LO registers, written by MULU/DIVU(/MULS) only
//
// Optional: define SEQ_ALU_SIGNED_MUL_EN to turn opcode 15 into MULS.

module seq_alu #(
  parameter int N     = 16,
  parameter int SEL_W = 4,
  parameter int SH_W  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [SEL_W-1:0] selector,
  input  logic             start,
  output logic [N-1:0]     result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     hi,
  output logic [N-1:0]     lo
);

  localparam int CW = $clog2(N);

  localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_NOR  = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_SLT  = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_SLTU = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_SLL  = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_SRL  = SEL_W'(9);
  localparam logic [SEL_W-1:0] OP_SRA  = SEL_W'(10);
  localparam logic [SEL_W-1:0] OP_MULU = SEL_W'(11);
  localparam logic [SEL_W-1:0] OP_DIVU = SEL_W'(12);
  localparam logic [SEL_W-1:0] OP_MFHI = SEL_W'(13);
  localparam logic [SEL_W-1:0] OP_MFLO = SEL_W'(14);
`ifdef SEQ_ALU_SIGNED_MUL_EN
  localparam logic [SEL_W-1:0] OP_MULS = SEL_W'(15);
`endif

`ifdef SEQ_ALU_SIGNED_MUL_EN
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;
`else
  typedef enum logic {
    IDLE,
    RUN
  } state_t;
`endif

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [N-1:0]  acc_hi, acc_lo;
  logic [N-1:0]  opb_q;
  logic          op_div_q;
`ifdef SEQ_ALU_SIGNED_MUL_EN
  logic          muls_q;
  logic          neg_q;
  logic          is_muls;
  logic [N-1:0]  mag_a, mag_b;
  logic [2*N-1:0] prod;
`endif

  // single-cycle datapath
  logic [N-1:0]    sum, diff, alu_res;
  logic            alu_ovf;
  logic [SH_W-1:0] sh;

  assign sh   = b[SH_W-1:0];
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (selector)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[N-1] == b[N-1]) &&
                  (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[N-1] != b[N-1]) &&
                  (diff[N-1] != a[N-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(N-1){1'b0}},
                          ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(N-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
      // only reaches here as the b==0 early-out
      OP_DIVU: alu_res = '1;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // op classification
  logic is_mul, is_div, is_divz, mc_op;

  assign is_mul  = (selector == OP_MULU);
  assign is_div  = (selector == OP_DIVU) && (b != '0);
  assign is_divz = (selector == OP_DIVU) && (b == '0);

`ifdef SEQ_ALU_SIGNED_MUL_EN
  assign is_muls = (selector == OP_MULS);
  assign mc_op   = is_mul | is_div | is_muls;
  assign mag_a   = a[N-1] ? -a : a;
  assign mag_b   = b[N-1] ? -b : b;
  assign prod    = {acc_hi, acc_lo};
`else
  assign mc_op   = is_mul | is_div;
`endif

  // one iteration of shift-add multiply or restoring divide
  logic [N:0]   msum;
  logic [N:0]   dshift;
  logic [N-1:0] dsub;
  logic         dge;
  logic [N-1:0] step_hi, step_lo;

  always_comb begin
    msum    = {1'b0, acc_hi} +
              (acc_lo[0] ? {1'b0, opb_q} : '0);
    dshift  = {acc_hi, acc_lo[N-1]};
    dge     = (dshift >= {1'b0, opb_q});
    // remainder < divisor, so the low N bits suffice
    dsub    = dshift[N-1:0] - opb_q;
    step_hi = '0;
    step_lo = '0;
    if (op_div_q) begin
      step_hi = dge ? dsub : dshift[N-1:0];
      step_lo = {acc_lo[N-2:0], dge};
    end else begin
      step_hi = msum[N:1];
      step_lo = {msum[0], acc_lo[N-1:1]};
    end
  end

  // FSM next state and strobes
  logic go_single, go_multi, last, fin;

  always_comb begin
    state_d   = state_q;
    go_single = 1'b0;
    go_multi  = 1'b0;
    last      = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mc_op) begin
            go_multi = 1'b1;
            state_d  = RUN;
          end else begin
            go_single = 1'b1;
          end
        end
      end
      RUN: begin
        last = (cnt_q == CW'(N-1));
        if (last) begin
`ifdef SEQ_ALU_SIGNED_MUL_EN
          if (muls_q) begin
            state_d = FIX;
          end else begin
            state_d = IDLE;
            fin     = 1'b1;
          end
`else
          state_d = IDLE;
          fin     = 1'b1;
`endif
        end
      end
`ifdef SEQ_ALU_SIGNED_MUL_EN
      FIX: begin
        state_d = IDLE;
        fin     = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // final hi/lo: last iteration value, or sign fix-up
  logic [N-1:0] fin_hi, fin_lo;

  always_comb begin
    fin_hi = step_hi;
    fin_lo = step_lo;
`ifdef SEQ_ALU_SIGNED_MUL_EN
    if (state_q == FIX) begin
      {fin_hi, fin_lo} = neg_q ? -prod : prod;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      cnt_q       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb_q       <= '0;
      op_div_q    <= 1'b0;
`ifdef SEQ_ALU_SIGNED_MUL_EN
      muls_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (go_single) begin
        result      <= alu_res;
        zero        <= (alu_res == '0);
        overflow    <= alu_ovf;
        div_by_zero <= is_divz;
        done        <= 1'b1;
        if (is_divz) begin
          hi <= a;
          lo <= '1;
        end
      end

      if (go_multi) begin
        cnt_q    <= '0;
        op_div_q <= is_div;
        acc_hi   <= '0;
        acc_lo   <= a;
        opb_q    <= b;
`ifdef SEQ_ALU_SIGNED_MUL_EN
        muls_q   <= is_muls;
        neg_q    <= is_muls & (a[N-1] ^ b[N-1]);
        if (is_muls) begin
          acc_lo <= mag_a;
          opb_q  <= mag_b;
        end
`endif
      end

      if (state_q == RUN) begin
        cnt_q  <= cnt_q + CW'(1);
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end

      if (fin) begin
        hi          <= fin_hi;
        lo          <= fin_lo;
        result      <= fin_lo;
        zero        <= (fin_lo == '0);
        overflow    <= 1'b0;
        div_by_zero <= 1'b0;
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (N=16).
// Expected values come from a behavioural model at issue time.

module tb_seq_alu;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [3:0]  selector;
  logic        start;
  logic [15:0] result, hi, lo;
  logic        zero, overflow, div_by_zero;
  logic        busy, done;

  always #5 clk = ~clk;

  seq_alu #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .selector(selector),
    .start(start),
    .result(result),
    .zero(zero),
    .overflow(overflow),
    .div_by_zero(div_by_zero),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        v;
    logic        dz;
    logic [15:0] h;
    logic [15:0] l;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e, mon_got;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] hi_m = '0;
  logic [15:0] lo_m = '0;

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [15:0] x,
                                 input logic [15:0] y);
    exp_t        e;
    int          s;
    logic [31:0] p;
    logic [3:0]  sh;
    e  = '0;
    sh = y[3:0];
    case (op)
      4'd0: begin
        s = int'($signed(x)) + int'($signed(y));
        e.r = x + y;
        e.v = (s > 32767) || (s < -32768);
      end
      4'd1: begin
        s = int'($signed(x)) - int'($signed(y));
        e.r = x - y;
        e.v = (s > 32767) || (s < -32768);
      end
      4'd2: e.r = x & y;
      4'd3: e.r = x | y;
      4'd4: e.r = x ^ y;
      4'd5: e.r = ~(x | y);
      4'd6: e.r = (int'($signed(x)) < int'($signed(y))) ? 16'd1 : 16'd0;
      4'd7: e.r = (x < y) ? 16'd1 : 16'd0;
      4'd8: e.r = x << sh;
      4'd9: e.r = x >> sh;
      4'd10: e.r = 16'($signed(x) >>> sh);
      4'd11: begin
        p = {16'd0, x} * {16'd0, y};
        hi_m = p[31:16];
        lo_m = p[15:0];
        e.r = lo_m;
      end
      4'd12: begin
        if (y == 16'd0) begin
          hi_m = x;
          lo_m = 16'hFFFF;
          e.dz = 1'b1;
        end else begin
          lo_m = x / y;
          hi_m = x % y;
        end
        e.r = lo_m;
      end
      4'd13: e.r = hi_m;
      4'd14: e.r = lo_m;
      default: begin
`ifdef SEQ_ALU_SIGNED_MUL_EN
        s = int'($signed(x)) * int'($signed(y));
        p = s;
        hi_m = p[31:16];
        lo_m = p[15:0];
        e.r = lo_m;
`else
        e.r = 16'd0;
`endif
      end
    endcase
    e.z = (e.r == 16'd0);
    e.h = hi_m;
    e.l = lo_m;
    return e;
  endfunction

  // scoreboard consumer
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_done result=%h required=no done",
                 result);
      end else begin
        mon_e   = sb.pop_front();
        mon_got = {result, zero, overflow, div_by_zero, hi, lo};
        if (mon_got !== mon_e) begin
          failures++;
          $display("FAIL scoreboard got r=%h z=%b v=%b dz=%b hi=%h lo=%h required r=%h z=%b v=%b dz=%b hi=%h lo=%h",
                   result, zero, overflow, div_by_zero, hi, lo,
                   mon_e.r, mon_e.z, mon_e.v, mon_e.dz,
                   mon_e.h, mon_e.l);
        end
      end
    end
  end

  // drive one op for one cycle; returns at the negedge after sampling
  task automatic issue(input logic [3:0] op,
                       input logic [15:0] x,
                       input logic [15:0] y);
    @(negedge clk);
    selector = op;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(op, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    selector = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({result, zero, overflow, div_by_zero, busy, done, hi, lo} !== '0) begin
      failures++;
      $display("FAIL reset_state r=%h z=%b v=%b dz=%b busy=%b done=%b hi=%h lo=%h required all 0",
               result, zero, overflow, div_by_zero, busy, done, hi, lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    issue(4'd0, 16'h7FFF, 16'h0001);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL add_latency done=%b required 1", done);
    end
    checks++;
    if (overflow !== 1'b1 || result !== 16'h8000) begin
      failures++;
      $display("FAIL add_ovf r=%h v=%b required 8000 1",
               result, overflow);
    end
    issue(4'd10, 16'h8000, 16'h0004);
    checks++;
    if (result !== 16'hF800) begin
      failures++;
      $display("FAIL sra result=%h required f800", result);
    end
    issue(4'd1, 16'h0002, 16'h0002);
    checks++;
    if (zero !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL sub_zero z=%b v=%b required 1 0",
               zero, overflow);
    end
    issue(4'd6, 16'hFFFF, 16'h0001);
    checks++;
    if (result !== 16'd1) begin
      failures++;
      $display("FAIL slt result=%h required 0001", result);
    end
    issue(4'd7, 16'hFFFF, 16'h0001);
    checks++;
    if (result !== 16'd0) begin
      failures++;
      $display("FAIL sltu result=%h required 0000", result);
    end
    issue(4'd8, 16'h0001, 16'hFFFF);
    issue(4'd1, 16'h8000, 16'h0001);
    issue(4'd5, 16'h0F0F, 16'h00F0);
    issue(4'd15, 16'h1234, 16'h5678);
`ifndef SEQ_ALU_SIGNED_MUL_EN
    checks++;
    if (done !== 1'b1 || result !== 16'd0) begin
      failures++;
      $display("FAIL reserved done=%b r=%h required 1 0000",
               done, result);
    end
`else
    repeat (N + 2) @(negedge clk);
`endif
  endtask

  task automatic test_mulu();
    int busy_cnt;
    int done_at;
    int extra;
    busy_cnt = 0;
    done_at = -1;
    extra = 0;
    issue(4'd11, 16'h1234, 16'h0100);
    if (busy) busy_cnt++;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      if (k == 4) begin
        selector = 4'd0;
        a = 16'h0001;
        b = 16'h0001;
        start = 1'b1;
      end
      if (k == 5) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        if (done_at < 0) done_at = k;
        else extra++;
      end
    end
    checks++;
    if (busy_cnt != N) begin
      failures++;
      $display("FAIL mulu_busy cycles=%0d required %0d",
               busy_cnt, N);
    end
    checks++;
    if (done_at != N) begin
      failures++;
      $display("FAIL mulu_latency done_at=%0d required %0d",
               done_at, N);
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL mulu_ignored_start extra_done=%0d required 0",
               extra);
    end
    checks++;
    if (hi !== 16'h0012 || lo !== 16'h3400) begin
      failures++;
      $display("FAIL mulu_hilo hi=%h lo=%h required 0012 3400",
               hi, lo);
    end
  endtask

  task automatic test_divu();
    int done_at;
    done_at = -1;
    issue(4'd12, 16'h0064, 16'h0007);
    for (int k = 1; k <= N + 2; k++) begin
      @(negedge clk);
      if (done && done_at < 0) done_at = k;
    end
    checks++;
    if (done_at != N) begin
      failures++;
      $display("FAIL divu_latency done_at=%0d required %0d",
               done_at, N);
    end
    issue(4'd13, 16'h0000, 16'h0000);
    checks++;
    if (result !== 16'h0002) begin
      failures++;
      $display("FAIL mfhi result=%h required 0002", result);
    end
    issue(4'd14, 16'h0000, 16'h0000);
    checks++;
    if (result !== 16'h000E) begin
      failures++;
      $display("FAIL mflo result=%h required 000e", result);
    end
  endtask

  task automatic test_div_zero();
    issue(4'd12, 16'h1234, 16'h0000);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL divz_handshake done=%b busy=%b required 1 0",
               done, busy);
    end
    checks++;
    if (div_by_zero !== 1'b1 || lo !== 16'hFFFF || hi !== 16'h1234) begin
      failures++;
      $display("FAIL divz_regs dz=%b hi=%h lo=%h required 1 1234 ffff",
               div_by_zero, hi, lo);
    end
    issue(4'd0, 16'h0003, 16'h0004);
    checks++;
    if (div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL divz_clear dz=%b required 0", div_by_zero);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    issue(4'd11, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    checks++;
    if ({busy, done, hi, lo, result} !== '0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h r=%h required all 0",
               busy, done, hi, lo, result);
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_mid_done count=%0d required 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [15:0] xs  [4];
    int          dcnt;
    ops = '{4'd0, 4'd4, 4'd9, 4'd1};
    xs  = '{16'h0100, 16'hAAAA, 16'hF000, 16'h0005};
    dcnt = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (done) dcnt++;
      end
      selector = ops[i];
      a = xs[i];
      b = 16'h0003;
      start = 1'b1;
      sb.push_back(model(ops[i], xs[i], 16'h0003));
    end
    @(negedge clk);
    if (done) dcnt++;
    start = 1'b0;
    checks++;
    if (dcnt != 4) begin
      failures++;
      $display("FAIL back_to_back dones=%0d required 4", dcnt);
    end
  endtask

`ifdef SEQ_ALU_SIGNED_MUL_EN
  task automatic test_muls();
    int done_at;
    done_at = -1;
    issue(4'd15, 16'hFFFE, 16'h0003);
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      if (done && done_at < 0) done_at = k;
    end
    checks++;
    if (done_at != N + 1) begin
      failures++;
      $display("FAIL muls_latency done_at=%0d required %0d",
               done_at, N + 1);
    end
    checks++;
    if (hi !== 16'hFFFF || lo !== 16'hFFFA) begin
      failures++;
      $display("FAIL muls_hilo hi=%h lo=%h required ffff fffa",
               hi, lo);
    end
  endtask
`endif

  task automatic test_random();
    int          k;
    logic [3:0]  op;
    logic [15:0] x, y;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = 16'($urandom);
      y  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      issue(op, x, y);
      k = 0;
      while (busy && k < 40) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (k >= 40) begin
        failures++;
        $display("FAIL random_timeout op=%0d busy=%b required 0",
                 op, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mulu();
    test_divu();
    test_div_zero();
    test_back_to_back();
`ifdef SEQ_ALU_SIGNED_MUL_EN
    test_muls();
`endif
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
